// File: rtl/sensor_xbar_pkg.sv
// Shared types and reply codes for the sensor command router.
package sensor_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam logic [7:0] ERR_UNKNOWN = 8'h3F;
  localparam logic [7:0] ERR_TIMEOUT = 8'h45;

endpackage

// File: rtl/sensor_cmd_router_if.sv
// UART byte link: command bytes in, response bytes out under valid/ready.
interface sensor_cmd_router_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // UART side drives commands and back-pressure
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  // router side consumes commands and produces the response stream
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/resp_serializer.sv
// Holds one response word and streams it LSB byte first over valid/ready.
module resp_serializer #(
  parameter int unsigned MAX_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*MAX_BYTES-1:0] load_data,
  input  logic [3:0]             load_len,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   done
);
  localparam int unsigned DW = 8 * MAX_BYTES;

  logic [DW-1:0] buffer;
  logic [DW-1:0] shifted;
  logic [3:0]    len;
  logic [3:0]    idx;
  logic          last;

  assign shifted = buffer >> 8;
  assign last    = (idx == len - 4'd1);
  assign done    = tx_valid && tx_ready && last;

  // buffer shifts down one byte per handshake so the next byte is always [7:0]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer   <= '0;
      len      <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      buffer   <= load_data;
      len      <= load_len;
      idx      <= '0;
      tx_data  <= load_data[7:0];
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (last) begin
        buffer   <= '0;
        len      <= '0;
        idx      <= '0;
        tx_data  <= '0;
        tx_valid <= 1'b0;
      end else begin
        buffer  <= shifted;
        idx     <= idx + 4'd1;
        tx_data <= shifted[7:0];
      end
    end
  end
endmodule

// File: rtl/sensor_cmd_router.sv
// Decodes one-byte commands, triggers the matching sensor, and replies with
// its data, a timeout error, or an unknown-command error.
module sensor_cmd_router
  import sensor_xbar_pkg::*;
#(
  parameter int unsigned          N_CH           = 2,
  parameter int unsigned          MAX_BYTES      = 5,
  parameter logic [N_CH*8-1:0]    CMD_CODES      = {8'h44, 8'h54},
  parameter logic [N_CH*4-1:0]    CH_BYTES       = {4'd2, 4'd5},
  parameter int unsigned          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  sensor_cmd_router_if.slave          link,
  output logic [N_CH-1:0]             sens_start,
  input  logic [N_CH*8*MAX_BYTES-1:0] sens_data,
  input  logic [N_CH-1:0]             sens_valid,
  output logic                        busy
);
  localparam int unsigned DW  = 8 * MAX_BYTES;
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [CHW-1:0]  ch, ch_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_CH-1:0] start_n;

  logic            hit;
  logic [CHW-1:0]  hit_ch;

  logic            load;
  logic [DW-1:0]   load_data;
  logic [3:0]      load_len;
  logic            done;
  logic [7:0]      tx_data;
  logic            tx_valid;

  // lowest matching index wins
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!hit && link.rx_data == CMD_CODES[8*i +: 8]) begin
        hit    = 1'b1;
        hit_ch = CHW'(i);
      end
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    cnt_n     = cnt;
    start_n   = '0;
    load      = 1'b0;
    load_data = '0;
    load_len  = '0;
    case (state)
      IDLE: begin
        if (link.rx_valid) begin
          if (hit) begin
            ch_n    = hit_ch;
            start_n = N_CH'(1) << hit_ch;
            state_n = START;
          end else begin
            load      = 1'b1;
            load_data = DW'(ERR_UNKNOWN);
            load_len  = 4'd1;
            state_n   = SEND;
          end
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // data takes priority over a timeout landing in the same cycle
        if (sens_valid[ch]) begin
          load      = 1'b1;
          load_data = sens_data[ch*DW +: DW];
          load_len  = CH_BYTES[ch*4 +: 4];
          state_n   = SEND;
        end else if (cnt == CNT_LAST) begin
          load      = 1'b1;
          load_data = DW'(ERR_TIMEOUT);
          load_len  = 4'd1;
          state_n   = SEND;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SEND: begin
        if (done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ch         <= '0;
      cnt        <= '0;
      sens_start <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ch         <= ch_n;
      cnt        <= cnt_n;
      sens_start <= start_n;
      busy       <= (state_n != IDLE);
    end
  end

  resp_serializer #(.MAX_BYTES(MAX_BYTES)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .tx_ready  (link.tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (done)
  );

  assign link.tx_data  = tx_data;
  assign link.tx_valid = tx_valid;
endmodule
